spike_count_classifier: RTL and testbench

SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

---
 rtl/snn_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/spike_count_classifier.sv | 162 ++++++++++++++++
 tb/tb_spike_count_classifier.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types for the spike-count classifier: FSM state encoding and class-index width.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_HOLD   = 2'd3
  } classifier_state_t;

  // Width of a class index; never narrower than one bit.
  function automatic int cls_idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-class spike counter: synchronous clear, increment that sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Counts output-layer spikes over a window, then picks the winning class by a serial argmax.
//
// state  | meaning
// IDLE   | waiting for start; result outputs keep last values
// ACCUM  | sampling spikes_in for W cycles into per-class counters
// ARGMAX | scanning one class per cycle for the largest count
// HOLD   | class_valid high until the consumer takes the result
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES  = 3,
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [WINDOW_WIDTH-1:0]               window_len,
  input  logic [NUM_CLASSES-1:0]                spikes_in,
  output logic                                  busy,
  output logic                                  class_valid,
  input  logic                                  class_ready,
  output logic [cls_idx_width(NUM_CLASSES)-1:0] class_id,
  output logic [COUNT_WIDTH-1:0]                class_count,
  output logic                                  class_tie,
  output logic                                  no_spike
);

  localparam int IDW = cls_idx_width(NUM_CLASSES);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_CLASSES - 1);

  classifier_state_t state_q, state_d;
  logic [WINDOW_WIDTH-1:0] len_q, len_d, win_q, win_d;
  logic [IDW-1:0]          idx_q, idx_d, best_id_q, best_id_d;
  logic [COUNT_WIDTH-1:0]  best_q, best_d;
  logic                    tie_q, tie_d;
  logic                    valid_q, valid_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [COUNT_WIDTH-1:0]  cnt_out_q, cnt_out_d;
  logic                    tie_out_q, tie_out_d, nospk_q, nospk_d;

  logic                    clr;
  logic [NUM_CLASSES-1:0]  inc;
  logic [COUNT_WIDTH-1:0]  cnt [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0]  cur;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[k]),
      .count (cnt[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    win_d     = win_q;
    idx_d     = idx_q;
    best_id_d = best_id_q;
    best_d    = best_q;
    tie_d     = tie_q;
    valid_d   = valid_q;
    id_d      = id_q;
    cnt_out_d = cnt_out_q;
    tie_out_d = tie_out_q;
    nospk_d   = nospk_q;
    clr       = 1'b0;
    inc       = '0;
    cur       = cnt[idx_q];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero-length window is run as a single-sample window.
          len_d   = (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
          win_d   = '0;
          clr     = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        inc   = spikes_in;
        win_d = win_q + 1'b1;
        if (win_d == len_q) begin
          idx_d   = '0;
          state_d = ST_ARGMAX;
        end
      end
      ST_ARGMAX: begin
        if (idx_q == '0) begin
          best_d    = cur;
          best_id_d = '0;
          tie_d     = 1'b0;
        end else if (cur > best_q) begin
          best_d    = cur;
          best_id_d = idx_q;
          tie_d     = 1'b0;
        end else if (cur == best_q) begin
          tie_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          id_d      = best_id_d;
          cnt_out_d = best_d;
          tie_out_d = tie_d;
          nospk_d   = (best_d == '0);
          valid_d   = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (class_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      win_q     <= '0;
      idx_q     <= '0;
      best_id_q <= '0;
      best_q    <= '0;
      tie_q     <= 1'b0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      cnt_out_q <= '0;
      tie_out_q <= 1'b0;
      nospk_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      best_id_q <= best_id_d;
      best_q    <= best_d;
      tie_q     <= tie_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      cnt_out_q <= cnt_out_d;
      tie_out_q <= tie_out_d;
      nospk_q   <= nospk_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign class_valid = valid_q;
  assign class_id    = id_q;
  assign class_count = cnt_out_q;
  assign class_tie   = tie_out_q;
  assign no_spike    = nospk_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier: default build plus a 4-bit-counter build for saturation.
module tb_spike_count_classifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window_len = '0;
  logic [2:0]  spikes_in = '0;
  logic        class_ready = 1'b0;

  logic        busy, class_valid, class_tie, no_spike;
  logic [1:0]  class_id;
  logic [7:0]  class_count;
  logic        busy4, valid4, tie4, nospk4;
  logic [1:0]  id4;
  logic [3:0]  count4;

  int total = 0;
  int bad = 0;
  logic [2:0] pat [64];

  always #5 clk = ~clk;

  spike_count_classifier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .spikes_in(spikes_in), .busy(busy), .class_valid(class_valid),
    .class_ready(class_ready), .class_id(class_id), .class_count(class_count),
    .class_tie(class_tie), .no_spike(no_spike)
  );

  spike_count_classifier #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .spikes_in(spikes_in), .busy(busy4), .class_valid(valid4),
    .class_ready(class_ready), .class_id(id4), .class_count(count4),
    .class_tie(tie4), .no_spike(nospk4)
  );

  // Start in cycle T, feed pat[0..w_eff-1] on T+1..T+W, then count cycles until class_valid.
  task automatic run_window(input logic [15:0] wl, input int w_eff, input bit poke, output int lat);
    @(negedge clk);
    start = 1'b1; window_len = wl; spikes_in = '0;
    for (int i = 0; i < w_eff; i++) begin
      @(negedge clk);
      start = (poke && i == 1);
      spikes_in = pat[i];
    end
    @(negedge clk);
    start = 1'b0;
    spikes_in = 3'b111;
    lat = w_eff + 1;
    while (!class_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    spikes_in = '0;
  endtask

  task automatic handshake();
    @(negedge clk); class_ready = 1'b1;
    @(negedge clk); class_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (class_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", class_valid); end
    total++; if ({class_id, class_count, class_tie, no_spike} !== 12'd0)
      begin bad++; $display("FAIL reset_result got=%h exp=0", {class_id, class_count, class_tie, no_spike}); end
    total++; if ({busy4, valid4, id4, count4, tie4, nospk4} !== 10'd0)
      begin bad++; $display("FAIL reset_dut4 got=%h exp=0", {busy4, valid4, id4, count4, tie4, nospk4}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b exp=0", busy); end
  endtask

  task automatic test_single_class();
    int lat;
    for (int i = 0; i < 10; i++) pat[i] = 3'b010;
    run_window(16'd10, 10, 1'b1, lat);
    total++; if (lat != 14) begin bad++; $display("FAIL single_latency got=%0d exp=14", lat); end
    total++; if (class_id !== 2'd1) begin bad++; $display("FAIL single_id got=%0d exp=1", class_id); end
    total++; if (class_count !== 8'd10) begin bad++; $display("FAIL single_count got=%0d exp=10", class_count); end
    total++; if ({class_tie, no_spike} !== 2'b00) begin bad++; $display("FAIL single_flags got=%b exp=00", {class_tie, no_spike}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    handshake();
    total++; if ({busy, class_valid} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", {busy, class_valid}); end
    total++; if ({class_id, class_count} !== {2'd1, 8'd10})
      begin bad++; $display("FAIL single_retain got=%0d/%0d exp=1/10", class_id, class_count); end
  endtask

  task automatic test_tie();
    int lat;
    pat[0] = 3'b101; pat[1] = 3'b101; pat[2] = 3'b101; pat[3] = 3'b000;
    run_window(16'd4, 4, 1'b0, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL tie_latency got=%0d exp=8", lat); end
    total++; if ({class_id, class_count, class_tie, no_spike} !== {2'd0, 8'd3, 1'b1, 1'b0})
      begin bad++; $display("FAIL tie_result got=%0d/%0d/%b/%b exp=0/3/1/0", class_id, class_count, class_tie, no_spike); end
    handshake();
  endtask

  task automatic test_saturation();
    int lat;
    for (int i = 0; i < 40; i++) pat[i] = 3'b100;
    run_window(16'd40, 40, 1'b0, lat);
    total++; if (lat != 44) begin bad++; $display("FAIL sat_latency got=%0d exp=44", lat); end
    total++; if (valid4 !== 1'b1) begin bad++; $display("FAIL sat_valid4 got=%b exp=1", valid4); end
    total++; if ({id4, count4, tie4, nospk4} !== {2'd2, 4'd15, 1'b0, 1'b0})
      begin bad++; $display("FAIL sat_result4 got=%0d/%0d/%b/%b exp=2/15/0/0", id4, count4, tie4, nospk4); end
    total++; if ({class_id, class_count} !== {2'd2, 8'd40})
      begin bad++; $display("FAIL sat_result8 got=%0d/%0d exp=2/40", class_id, class_count); end
    handshake();
    // Two saturated classes must tie: classes 0 and 1 spike 20 times each.
    for (int i = 0; i < 20; i++) pat[i] = 3'b011;
    run_window(16'd20, 20, 1'b0, lat);
    total++; if ({id4, count4, tie4} !== {2'd0, 4'd15, 1'b1})
      begin bad++; $display("FAIL sat_tie4 got=%0d/%0d/%b exp=0/15/1", id4, count4, tie4); end
    handshake();
  endtask

  task automatic test_zero_len();
    int lat;
    pat[0] = 3'b000;
    run_window(16'd0, 1, 1'b0, lat);
    total++; if (lat != 5) begin bad++; $display("FAIL zero_latency got=%0d exp=5", lat); end
    total++; if ({class_id, class_count, class_tie, no_spike} !== {2'd0, 8'd0, 1'b1, 1'b1})
      begin bad++; $display("FAIL zero_result got=%0d/%0d/%b/%b exp=0/0/1/1", class_id, class_count, class_tie, no_spike); end
    handshake();
  endtask

  task automatic test_hold();
    int lat;
    int unstable = 0;
    pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b001;
    run_window(16'd3, 3, 1'b1, lat);
    total++; if ({class_id, class_count, class_tie} !== {2'd0, 8'd3, 1'b0})
      begin bad++; $display("FAIL hold_result got=%0d/%0d/%b exp=0/3/0", class_id, class_count, class_tie); end
    for (int i = 0; i < 20; i++) begin
      start = i[0]; spikes_in = 3'b111;
      @(negedge clk);
      if ({class_valid, class_id, class_count, class_tie, no_spike} !== {1'b1, 2'd0, 8'd3, 1'b0, 1'b0})
        unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL hold_stable unstable_cycles=%0d exp=0", unstable); end
    start = 1'b1; class_ready = 1'b1; spikes_in = '0;
    @(negedge clk);
    start = 1'b0; class_ready = 1'b0;
    total++; if ({busy, class_valid} !== 2'b00) begin bad++; $display("FAIL hold_release got=%b exp=00", {busy, class_valid}); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_start_ignored busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray = 0;
    @(negedge clk); start = 1'b1; window_len = 16'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b0; spikes_in = 3'b010;
    end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, class_valid, class_id, class_count, class_tie, no_spike} !== 14'd0)
      begin bad++; $display("FAIL midreset_outputs got=%h exp=0", {busy, class_valid, class_id, class_count, class_tie, no_spike}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (class_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL midreset_no_result stray_cycles=%0d exp=0", stray); end
    spikes_in = '0;
    pat[0] = 3'b100; pat[1] = 3'b100; pat[2] = 3'b100;
    run_window(16'd3, 3, 1'b0, lat);
    total++; if (lat != 7) begin bad++; $display("FAIL midreset_latency got=%0d exp=7", lat); end
    total++; if ({class_id, class_count, class_tie} !== {2'd2, 8'd3, 1'b0})
      begin bad++; $display("FAIL midreset_result got=%0d/%0d/%b exp=2/3/0", class_id, class_count, class_tie); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_class();
    test_tie();
    test_saturation();
    test_zero_len();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
